// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file writeback path.
// Widths here are the defaults that the parameterised modules start from.
package regfile_pkg;

    localparam int AWL_DEF = 5;
    localparam int DWL_DEF = 32;

    typedef logic [AWL_DEF-1:0] reg_addr_t;
    typedef logic [DWL_DEF-1:0] reg_data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant for NREQ requesters; search starts just after i_ptr.
// Purely combinational so the owner decides when the pointer moves.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_idx   = 0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_idx        = w_idx[PW-1:0];
                w_found      = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single write port owner for the 2R/1W register file: round-robin writeback
// arbitration, one registered write stage, read forwarding and busy scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int AWL      = AWL_DEF,
    parameter int DWL      = DWL_DEF,
    parameter int NREQ     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*AWL-1:0] req_addr,
    input  logic [NREQ*DWL-1:0] req_data,
    output logic                rf_wen,
    output logic [AWL-1:0]      rf_wa,
    output logic [DWL-1:0]      rf_wd,
    input  logic [AWL-1:0]      ra1,
    input  logic [AWL-1:0]      ra2,
    input  logic [DWL-1:0]      rf_rd1,
    input  logic [DWL-1:0]      rf_rd2,
    output logic [DWL-1:0]      rd1,
    output logic [DWL-1:0]      rd2,
    input  logic                sb_set,
    input  logic [AWL-1:0]      sb_set_addr,
    output logic                busy1,
    output logic                busy2
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << AWL;

    logic [NREQ-1:0] w_valid;
    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_gidx;
    logic            w_any;
    logic [AWL-1:0]  w_gaddr;
    logic [DWL-1:0]  w_gdata;
    logic            w_zero_gnt;
    logic            w_set_ok;
    logic [NREG-1:0] w_sb_nxt;

    logic [PW-1:0]   r_ptr;
    logic            r_wen;
    logic [AWL-1:0]  r_wa;
    logic [DWL-1:0]  r_wd;
    logic [NREG-1:0] r_sb;

    // Nothing is accepted while reset is held.
    assign w_valid = rst ? '0 : req_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_req (w_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    assign req_ready  = w_gnt;
    assign w_gaddr    = req_addr[int'(w_gidx)*AWL +: AWL];
    assign w_gdata    = req_data[int'(w_gidx)*DWL +: DWL];
    assign w_zero_gnt = (ZERO_REG != 0) && (w_gaddr == '0);
    assign w_set_ok   = sb_set &&
                        !((ZERO_REG != 0) && (sb_set_addr == '0));

    // Clear at grant, then a same-cycle set from a newer producer wins.
    always_comb begin
        w_sb_nxt = r_sb;
        if (w_any) begin
            w_sb_nxt[w_gaddr] = 1'b0;
        end
        if (w_set_ok) begin
            w_sb_nxt[sb_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= PW'(NREQ - 1);
            r_wen <= 1'b0;
            r_wa  <= '0;
            r_wd  <= '0;
            r_sb  <= '0;
        end else begin
            r_sb <= w_sb_nxt;
            if (w_any) begin
                r_wen <= !w_zero_gnt;
                r_wa  <= w_gaddr;
                r_wd  <= w_gdata;
                r_ptr <= w_gidx;
            end else begin
                r_wen <= 1'b0;
            end
        end
    end

    assign rf_wen = r_wen;
    assign rf_wa  = r_wa;
    assign rf_wd  = r_wd;

    always_comb begin
        rd1 = rf_rd1;
        rd2 = rf_rd2;
        if (r_wen && (r_wa == ra1)) begin
            rd1 = r_wd;
        end
        if (r_wen && (r_wa == ra2)) begin
            rd2 = r_wd;
        end
        if ((ZERO_REG != 0) && (ra1 == '0)) begin
            rd1 = '0;
        end
        if ((ZERO_REG != 0) && (ra2 == '0)) begin
            rd2 = '0;
        end
    end

    assign busy1 = r_sb[ra1];
    assign busy2 = r_sb[ra2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a negedge monitor models arbitration,
// write stage, forwarding and busy bits; directed phases plus a random phase.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        rf_wen;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        sb_set;
    logic [4:0]  sb_set_addr;
    logic        busy1;
    logic        busy2;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wexp_t;

    wexp_t       q[$];
    int          mptr = 1;
    logic [31:0] msb  = '0;
    logic [31:0] rf[32];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .AWL      (5),
        .DWL      (32),
        .NREQ     (2),
        .ZERO_REG (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_wen      (rf_wen),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .ra1         (ra1),
        .ra2         (ra2),
        .rf_rd1      (rf_rd1),
        .rf_rd2      (rf_rd2),
        .rd1         (rd1),
        .rd2         (rd2),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .busy1       (busy1),
        .busy2       (busy2)
    );

    // LUTRAM stand-in: async read, sync write, known contents after reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 | i;
        end else if (rf_wen) begin
            rf[rf_wa] <= rf_wd;
        end
    end
    assign rf_rd1 = rf[ra1];
    assign rf_rd2 = rf[ra2];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] exp_rd(logic [4:0] a, wexp_t c);
        if (a == 5'd0) return 32'd0;
        if (c.wen && c.wa == a) return c.wd;
        return rf[a];
    endfunction

    // Monitor: pop the write expected for this cycle, predict the next one.
    always @(negedge clk) begin
        wexp_t       cur;
        wexp_t       nxt;
        logic [1:0]  eg;
        int          gi;
        int          idx;
        logic [4:0]  ga;
        cur = '{1'b0, 5'd0, 32'd0};
        nxt = '{1'b0, 5'd0, 32'd0};
        eg  = 2'b00;
        gi  = 0;
        if (q.size() > 0) begin
            cur = q.pop_front();
            check("wen", rf_wen, cur.wen);
            if (cur.wen) begin
                check("wa", rf_wa, cur.wa);
                check("wd", rf_wd, cur.wd);
            end
            check("rd1", rd1, exp_rd(ra1, cur));
            check("rd2", rd2, exp_rd(ra2, cur));
            check("busy1", busy1, msb[ra1]);
            check("busy2", busy2, msb[ra2]);
        end
        if (!rst) begin
            for (int k = 1; k <= 2; k++) begin
                idx = (mptr + k) % 2;
                if (eg == 2'b00 && req_valid[idx]) begin
                    eg[idx] = 1'b1;
                    gi      = idx;
                end
            end
        end
        check("ready", req_ready, eg);
        if (rst) begin
            mptr = 1;
            msb  = '0;
        end else begin
            if (eg != 2'b00) begin
                ga      = req_addr[gi*5 +: 5];
                nxt.wen = (ga != 5'd0);
                nxt.wa  = ga;
                nxt.wd  = req_data[gi*32 +: 32];
                mptr    = gi;
                msb[ga] = 1'b0;
            end
            if (sb_set && sb_set_addr != 5'd0) msb[sb_set_addr] = 1'b1;
        end
        q.push_back(nxt);
    end

    task automatic nxt_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(int i, logic v, logic [4:0] a, logic [31:0] d);
        req_valid[i]        = v;
        req_addr[i*5 +: 5]  = a;
        req_data[i*32 +: 32] = d;
    endtask

    logic [1:0] rdy;

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        ra1         = '0;
        ra2         = '0;
        sb_set      = 1'b0;
        sb_set_addr = '0;
        nxt_cyc();
        nxt_cyc();
        rst = 1'b0;
        smp();
        check("rst_wen", rf_wen, 1'b0);
        for (int a = 0; a < 32; a += 7) begin
            nxt_cyc();
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            smp();
            check("idle_busy1", busy1, 1'b0);
            check("idle_busy2", busy2, 1'b0);
        end

        // Contention: both requesters held valid.
        nxt_cyc();
        set_req(0, 1'b1, 5'd3, 32'hAAAA_0000);
        set_req(1, 1'b1, 5'd4, 32'h5555_FFFF);
        for (int k = 0; k < 8; k++) begin
            smp();
            check("alt_gnt", req_ready, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) check("alt_wa", rf_wa, (k % 2) ? 5'd3 : 5'd4);
            nxt_cyc();
        end

        // Forwarding of the in-flight write.
        set_req(1, 1'b0, 5'd0, 32'd0);
        set_req(0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        smp();
        check("fwd_gnt", req_ready, 2'b01);
        nxt_cyc();
        set_req(0, 1'b0, 5'd0, 32'd0);
        ra1 = 5'd7;
        ra2 = 5'd7;
        smp();
        check("fwd_rd1", rd1, 32'hDEAD_BEEF);
        check("fwd_rd2", rd2, 32'hDEAD_BEEF);
        check("fwd_old", rf_rd1, 32'h1000_0007);
        nxt_cyc();
        smp();
        check("fwd_new", rf_rd1, 32'hDEAD_BEEF);

        // Zero register write is accepted and dropped.
        nxt_cyc();
        set_req(0, 1'b1, 5'd0, 32'h1234_5678);
        ra1 = 5'd0;
        smp();
        check("zero_gnt", req_ready, 2'b01);
        nxt_cyc();
        set_req(0, 1'b0, 5'd0, 32'd0);
        smp();
        check("zero_wen", rf_wen, 1'b0);
        check("zero_rd1", rd1, 32'd0);

        // Scoreboard set / same-cycle set+clear / clear.
        nxt_cyc();
        sb_set      = 1'b1;
        sb_set_addr = 5'd9;
        ra1         = 5'd9;
        nxt_cyc();
        sb_set = 1'b0;
        smp();
        check("sb_set", busy1, 1'b1);
        nxt_cyc();
        sb_set = 1'b1;
        set_req(0, 1'b1, 5'd9, 32'h0000_0099);
        smp();
        check("sb_both_gnt", req_ready, 2'b01);
        nxt_cyc();
        sb_set = 1'b0;
        set_req(0, 1'b0, 5'd0, 32'd0);
        smp();
        check("sb_set_wins", busy1, 1'b1);
        nxt_cyc();
        set_req(0, 1'b1, 5'd9, 32'h0000_009A);
        nxt_cyc();
        set_req(0, 1'b0, 5'd0, 32'd0);
        smp();
        check("sb_clear", busy1, 1'b0);

        // Random traffic; requesters hold until accepted.
        for (int c = 0; c < 80; c++) begin
            smp();
            rdy = req_ready;
            nxt_cyc();
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || rdy[i]) begin
                    set_req(i, 1'($urandom_range(0, 1)),
                            5'($urandom_range(0, 31)), $urandom);
                end
            end
            ra1         = 5'($urandom_range(0, 31));
            ra2         = 5'($urandom_range(0, 31));
            sb_set      = ($urandom_range(0, 3) == 0);
            sb_set_addr = 5'($urandom_range(0, 31));
        end

        // Reset in the cycle after a grant.
        smp();
        rdy = req_ready;
        nxt_cyc();
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && !rdy[i]) begin
                smp();
                nxt_cyc();
            end
        end
        set_req(0, 1'b0, 5'd0, 32'd0);
        set_req(1, 1'b0, 5'd0, 32'd0);
        sb_set = 1'b0;
        nxt_cyc();
        set_req(0, 1'b1, 5'd5, 32'h0000_0055);
        sb_set      = 1'b1;
        sb_set_addr = 5'd5;
        ra1         = 5'd5;
        smp();
        check("mr_gnt", req_ready, 2'b01);
        nxt_cyc();
        rst    = 1'b1;
        sb_set = 1'b0;
        set_req(1, 1'b1, 5'd6, 32'h0000_0066);
        smp();
        check("mr_rst_ready", req_ready, 2'b00);
        check("mr_pre_wen", rf_wen, 1'b1);
        check("mr_pre_busy", busy1, 1'b1);
        nxt_cyc();
        rst = 1'b0;
        smp();
        check("mr_wen", rf_wen, 1'b0);
        check("mr_busy", busy1, 1'b0);
        check("mr_first", req_ready, 2'b01);
        nxt_cyc();
        set_req(0, 1'b0, 5'd0, 32'd0);
        set_req(1, 1'b0, 5'd0, 32'd0);
        repeat (3) nxt_cyc();
        smp();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 2-read/1-write LUTRAM register file (asynchronous read, synchronous write, DWL-bit words, 2^AWL entries).
- Arbitrates NREQ writeback requesters (e.g. ALU, load unit) round-robin onto that port through one registered write stage.
- Forwards the in-flight write to both read ports and keeps a per-register busy scoreboard for issue-side hazard detection.

Parameters:
AWL, 5, register address width; file depth is 2^AWL.
DWL, 32, data width; even value, matching the register file.
NREQ, 2, number of writeback requesters; range 2..4.
ZERO_REG, 1, 1 makes address 0 hardwired zero (writes dropped, reads return 0).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NREQ  writeback request valid, one bit per requester.
req_ready  out  NREQ  request accepted this cycle (one-hot or zero).
req_addr  in  NREQ*AWL  destination register per requester; requester i at [i*AWL +: AWL].
req_data  in  NREQ*DWL  write data per requester; requester i at [i*DWL +: DWL].
rf_wen  out  1  register-file write enable.
rf_wa  out  AWL  register-file write address.
rf_wd  out  DWL  register-file write data.
ra1  in  AWL  read address, port 1; also drives the register file's port-1 address.
ra2  in  AWL  read address, port 2; also drives the register file's port-2 address.
rf_rd1  in  DWL  raw register-file read data, port 1.
rf_rd2  in  DWL  raw register-file read data, port 2.
rd1  out  DWL  forwarded read data, port 1.
rd2  out  DWL  forwarded read data, port 2.
sb_set  in  1  issue stage marks a destination register as pending.
sb_set_addr  in  AWL  register to mark pending.
busy1  out  1  scoreboard busy bit for ra1 (combinational).
busy2  out  1  scoreboard busy bit for ra2 (combinational).

Behaviour:
- Reset values: rf_wen=0, rf_wa=0, rf_wd=0, all scoreboard bits=0, round-robin pointer=NREQ-1 (requester 0 has first priority).
- Arbitration (combinational):
  - Search starts at pointer+1 modulo NREQ; first valid requester wins.
  - req_ready = one-hot grant; 0 when no req_valid is set. Never asserted during rst.
  - A requester holds req_valid/addr/data stable until its req_ready is seen.
- Write stage (registered):
  - The write stage never stalls, so throughput is one write per cycle.
  - On grant: rf_wen<=1, rf_wa<=addr, rf_wd<=data, pointer<=granted index.
  - With no grant: rf_wen<=0; rf_wa and rf_wd hold; pointer holds.
  - Latency: grant at cycle N, register file written at the edge ending cycle N+1.
- Zero register (ZERO_REG=1):
  - A grant with addr 0 is accepted (req_ready=1, pointer advances) but rf_wen<=0.
  - rd1/rd2 forced to 0 when ra1/ra2==0.
  - sb_set to address 0 is ignored.
- Forwarding (combinational):
  - rd1 = rf_wd if rf_wen && rf_wa==ra1, else rf_rd1. Same rule for rd2.
  - ZERO_REG override takes precedence over forwarding.
- Scoreboard (2^AWL bits), one edge per update:
  - Set on sb_set at sb_set_addr.
  - Cleared when a grant is accepted for that address (clear at grant time; forwarding covers the write cycle).
  - Set and clear to the same address in the same cycle: set wins (newer producer).
  - Set to an already-busy register: stays busy.
  - busy1 = sb[ra1], busy2 = sb[ra2].
- Reset mid-operation:
  - The pending write stage is discarded (rf_wen=0 on the next cycle).
  - The scoreboard clears; the pointer returns to NREQ-1.
  - Requests asserted during rst are not accepted.

Decomposition:
- Package regfile_pkg:
  - localparams AWL_DEF=5, DWL_DEF=32.
  - typedef reg_addr_t = logic[AWL-1:0].
  - typedef reg_data_t = logic[DWL-1:0].
  - typedef wb_req_t struct {valid, addr, data}.
- One sub-module: rr_arbiter (NREQ-wide round-robin grant with pointer input), reusable for other shared ports.
- Scoreboard and forwarding stay inline.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> rf_wen=0, busy1=busy2=0 for all ra1/ra2; first grant after reset goes to req0 when both requesters are valid.
- Contention: req0 (addr 3, 0xAAAA0000) and req1 (addr 4, 0x5555FFFF) held valid continuously -> grants alternate 0,1,0,1; rf_wa sequence 3,4,3,4 one cycle after each grant; each req_ready is one-hot.
- Forwarding: grant addr 7 data 0xDEADBEEF with ra1=ra2=7 on the following cycle -> rd1=rd2=0xDEADBEEF while rf_rd1 still returns the old value; the next cycle rf_rd1 itself returns 0xDEADBEEF.
- Zero register: req0 writes addr 0 data 0x12345678 -> req_ready=1, rf_wen stays 0, rd1 with ra1=0 reads 0.
- Scoreboard: sb_set addr 9 -> busy1=1 for ra1=9; grant addr 9 in the same cycle as sb_set addr 9 -> busy stays 1; a later grant to addr 9 with no set -> busy1=0 next cycle.
- Mid-operation reset: rst asserted in the cycle after a grant to addr 5 -> rf_wen=0 the following cycle, busy for 5 cleared, next grant goes to req0.
